// File: rtl/req_ack_arb_pkg.sv
// req_ack_arb_pkg: shared state encoding and default sizing for req_ack_arbiter
package req_ack_arb_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 16;
endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting one past the pointer
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 vld_o
);
    // scan from farthest to nearest so the index right after the pointer wins
    always_comb begin
        idx_o = '0;
        for (int k = N; k >= 1; k--)
            if (req_i[(int'(ptr_i) + k) % N]) idx_o = ($clog2(N))'((int'(ptr_i) + k) % N);
    end
    assign vld_o = |req_i;
endmodule

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin arbiter of N_REQ requesters onto one req/ack downstream port;
// define REQ_ACK_ARBITER_SVA_EN to compile the protocol assertions
import req_ack_arb_pkg::*;
module req_ack_arbiter #(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     dn_req_o,
    output logic [$clog2(N_REQ)-1:0] dn_id_o,
    input  logic                     dn_ack_i,
    output logic                     busy_o,
    output logic                     timeout_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] T_LAST  = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;
    state_t          state_q, state_d;
    logic [IW-1:0]   id_q, id_d, ptr_q, ptr_d, win_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d, win_vld, in_wait, expire;
    rr_pick #(.N(N_REQ)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );
    assign in_wait = state_q == WAIT_ACK;
    // next state; an ack arriving on the timeout cycle takes precedence over the abort
    always_comb begin
        expire  = in_wait && !dn_ack_i && (TIMEOUT_CYC != 0) && (cnt_q == T_LAST);
        state_d = (state_q == IDLE) ? (win_vld ? WAIT_ACK : IDLE)
                : in_wait ? (dn_ack_i ? DONE : (expire ? IDLE : WAIT_ACK))
                : IDLE;
        id_d    = (state_q == IDLE && win_vld) ? win_idx : id_q;
        ptr_d   = (state_q == DONE || expire) ? id_q : ptr_q;
        cnt_d   = !in_wait ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
        to_d    = expire;
    end
    // state registers; reset lands on IDLE with index 0 next in line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end
    assign dn_req_o  = in_wait;
    assign dn_id_o   = id_q;
    assign busy_o    = state_q != IDLE;
    assign timeout_o = to_q;
    assign ack_o     = (state_q == DONE) ? (N_REQ'(1) << id_q) : '0;
`ifdef REQ_ACK_ARBITER_SVA_EN
    generate
        if (TIMEOUT_CYC != 0) begin : g_sva_to
            a_hold: assert property (@(posedge clk) disable iff (rst)
                $rose(dn_req_o) |-> dn_req_o until (dn_ack_i || timeout_o));
        end else begin : g_sva_nto
            a_hold: assert property (@(posedge clk) disable iff (rst)
                $rose(dn_req_o) |-> dn_req_o s_until_with dn_ack_i);
        end
    endgenerate
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack_o));
    a_stable: assert property (@(posedge clk) disable iff (rst)
        dn_req_o && $past(dn_req_o) |-> $stable(dn_id_o));
`endif
endmodule
